// File: rtl/word_deserializer_pkg.sv
// Shared types and helpers for the word deserializer: FILL/FULL state encoding
// and the lane-count width function.
package word_deserializer_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  // Bits needed to hold the values 0..n, i.e. clog2(n+1); never narrower than 1
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned v = n; v != 0; v = v >> 1) w++;
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/word_lane_decoder.sv
// Turns the current fill index into a one-hot lane write-enable vector.
module word_lane_decoder #(
  parameter int unsigned LANES = 1,
  parameter int unsigned IDX_W = 1
) (
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  output logic [LANES-1:0] o_lane_we_c
);

  always_comb begin
    o_lane_we_c = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (i_en && (i_idx == IDX_W'(k))) o_lane_we_c[k] = 1'b1;
    end
  end

endmodule

// File: rtl/word_deserializer.sv
// Packs sequential words into lanes 0..WORD_COUNT-1 of a wide output bus.
// Optional early-flush port is enabled with `define WORD_DESERIALIZER_FLUSH_EN.
module word_deserializer
  import word_deserializer_pkg::*;
#(
  parameter  int unsigned WORD_WIDTH = 0,
  parameter  int unsigned WORD_COUNT = 0,
  localparam int unsigned CNT_W      = cnt_width(WORD_COUNT)
) (
  input  logic                             clock,
  input  logic                             reset,
`ifdef WORD_DESERIALIZER_FLUSH_EN
  input  logic                             flush,
`endif
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WORD_WIDTH-1:0]            in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORD_WIDTH*WORD_COUNT-1:0] out,
  output logic [CNT_W-1:0]                 out_count
);

  if (WORD_WIDTH == 0 || WORD_COUNT == 0) begin : g_bad_param
    $error("word_deserializer: WORD_WIDTH and WORD_COUNT must both be >= 1");
  end

  state_t                                  r_state;
  logic   [CNT_W-1:0]                      r_count;
  logic   [WORD_COUNT-1:0][WORD_WIDTH-1:0] r_lanes;
  logic                                    r_out_valid;

  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_flush;
  logic                  w_last;
  logic [WORD_COUNT-1:0] w_lane_we;

`ifdef WORD_DESERIALIZER_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_last     = (r_count == CNT_W'(WORD_COUNT - 1));

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out       = r_lanes;
  assign out_count = r_count;

  word_lane_decoder #(
    .LANES (WORD_COUNT),
    .IDX_W (CNT_W)
  ) u_lane_decoder (
    .i_idx       (r_count),
    .i_en        (w_accept && (r_state == ST_FILL)),
    .o_lane_we_c (w_lane_we)
  );

  // FILL collects words; FULL presents the group until the consumer takes it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_FILL;
      r_count     <= '0;
      r_lanes     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          for (int unsigned k = 0; k < WORD_COUNT; k++) begin
            if (w_lane_we[k]) r_lanes[k] <= in_data;
          end
          if (w_accept) r_count <= r_count + CNT_W'(1);
          if ((w_accept && w_last) || (w_flush && (w_accept || (r_count != '0)))) begin
            r_state     <= ST_FULL;
            r_out_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            r_lanes <= '0;
            if (w_accept) begin
              // Back-to-back: the new word starts the next group in lane 0
              r_lanes[0] <= in_data;
              r_count    <= CNT_W'(1);
              if (WORD_COUNT == 1) begin
                r_state     <= ST_FULL;
                r_out_valid <= 1'b1;
              end else begin
                r_state     <= ST_FILL;
                r_out_valid <= 1'b0;
              end
            end else begin
              r_count     <= '0;
              r_state     <= ST_FILL;
              r_out_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= ST_FILL;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_deserializer.sv
// Self-checking bench for word_deserializer (8-bit words, 4 lanes, plus a 1-lane
// instance); flush scenarios run when WORD_DESERIALIZER_FLUSH_EN is defined.
module tb_word_deserializer;

`ifdef WORD_DESERIALIZER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif
  localparam int unsigned WC = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, flush_s = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, out_valid;
  logic [31:0] out;
  logic [2:0]  out_count;

  logic       v1 = 1'b0, or1 = 1'b0;
  logic [7:0] d1 = '0;
  logic       ir1, ov1;
  logic [7:0] out1;
  logic       cnt1;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  word_deserializer #(.WORD_WIDTH(8), .WORD_COUNT(WC)) u_dut (
    .clock     (clock),
    .reset     (reset),
`ifdef WORD_DESERIALIZER_FLUSH_EN
    .flush     (flush_s),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_count (out_count)
  );

  word_deserializer #(.WORD_WIDTH(8), .WORD_COUNT(1)) u_dut1 (
    .clock     (clock),
    .reset     (reset),
`ifdef WORD_DESERIALIZER_FLUSH_EN
    .flush     (1'b0),
`endif
    .in_valid  (v1),
    .in_ready  (ir1),
    .in_data   (d1),
    .out_valid (ov1),
    .out_ready (or1),
    .out       (out1),
    .out_count (cnt1)
  );

  // Reference model: a queue of words in the current group plus a "presented" flag
  logic [7:0] m_q[$];
  bit         m_full;

  function automatic logic [31:0] model_out();
    logic [31:0] r;
    r = '0;
    foreach (m_q[i]) r = r | (32'(m_q[i]) << (8 * i));
    return r;
  endfunction

  task automatic model_step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    bit acc;
    acc = iv && (!m_full || ordy);
    if (m_full) begin
      if (ordy) begin
        m_q.delete();
        m_full = 1'b0;
        if (acc) begin
          m_q.push_back(d);
          if (m_q.size() == WC) m_full = 1'b1;
        end
      end
    end else begin
      if (acc) m_q.push_back(d);
      if (m_q.size() == WC || (FLUSH_EN && fl && m_q.size() > 0)) m_full = 1'b1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Inputs change 2 time units after the rising edge, outputs are sampled 1 unit later
  task automatic apply(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    @(posedge clock);
    #2;
    in_valid = iv; in_data = d; out_ready = ordy; flush_s = fl;
    #1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; flush_s = 1'b0; v1 = 1'b0; or1 = 1'b0;
    #1;
    chk("rst_out", out, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_count", 32'(out_count), 32'h0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    m_q.delete();
    m_full = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        ordy;
    logic        exp_ir;
    logic        exp_ov;
    logic [31:0] exp_out;
    logic [2:0]  exp_cnt;
  } vec_t;

  initial begin
    vec_t vt[18];
    int   groups;
    logic [7:0] prev;

    // Expected columns describe the state in effect before the row's clock edge
    vt[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 32'h00000000, 3'd0};
    vt[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 32'h00000011, 3'd1};
    vt[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 32'h00002211, 3'd2};
    vt[3]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 32'h00332211, 3'd3};
    vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h44332211, 3'd4};
    vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h00000000, 3'd0};
    vt[6]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h00000000, 3'd0};
    vt[7]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h00000011, 3'd1};
    vt[8]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 32'h00002211, 3'd2};
    vt[9]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 32'h00332211, 3'd3};
    for (int i = 10; i < 15; i++) vt[i] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 32'h44332211, 3'd4};
    vt[15] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 32'h44332211, 3'd4};
    vt[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h00000055, 3'd1};
    vt[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h00000055, 3'd1};

    #1;
    chk("init_rst_out", out, 32'h0);
    chk("init_rst_valid", 32'(out_valid), 32'h0);
    chk("init_rst_count", 32'(out_count), 32'h0);

    // Scenarios 2 and 3: single group, then backpressure and back-to-back reload
    do_reset();
    for (int i = 0; i < 18; i++) begin
      apply(vt[i].iv, vt[i].d, vt[i].ordy, 1'b0);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].exp_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].exp_ov));
      chk($sformatf("vec%0d_out", i), out, vt[i].exp_out);
      chk($sformatf("vec%0d_count", i), 32'(out_count), 32'(vt[i].exp_cnt));
    end

    // Scenario 1: reset discards a partial group
    do_reset();
    apply(1'b1, 8'hAA, 1'b1, 1'b0);
    apply(1'b1, 8'hBB, 1'b1, 1'b0);
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      apply(1'b1, 8'(i), 1'b1, 1'b0);
      chk($sformatf("s1_no_stale_valid%0d", i), 32'(out_valid), 32'h0);
    end
    apply(1'b0, 8'h00, 1'b1, 1'b0);
    chk("s1_valid", 32'(out_valid), 32'h1);
    chk("s1_out", out, 32'h04030201);
    chk("s1_count", 32'(out_count), 32'd4);

    // Scenario 4: 12 back-to-back words, three groups, no in_ready bubble
    do_reset();
    groups = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 12) apply(1'b1, 8'(i + 1), 1'b1, 1'b0);
      else        apply(1'b0, 8'h00, 1'b1, 1'b0);
      if (i < 12) chk($sformatf("s4_in_ready%0d", i), 32'(in_ready), 32'h1);
      if (out_valid) begin
        chk($sformatf("s4_group%0d", groups), out,
            {8'(4 * groups + 4), 8'(4 * groups + 3), 8'(4 * groups + 2), 8'(4 * groups + 1)});
        groups++;
      end
    end
    chk("s4_group_count", 32'(groups), 32'd3);

    if (FLUSH_EN) begin
      // Scenario 5: early flush of a partial group; flush while empty does nothing
      do_reset();
      apply(1'b1, 8'hAA, 1'b0, 1'b0);
      apply(1'b1, 8'hBB, 1'b0, 1'b0);
      apply(1'b0, 8'h00, 1'b0, 1'b1);
      chk("s5_pre_valid", 32'(out_valid), 32'h0);
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      chk("s5_valid", 32'(out_valid), 32'h1);
      chk("s5_out", out, 32'h0000BBAA);
      chk("s5_count", 32'(out_count), 32'd2);
      apply(1'b0, 8'h00, 1'b0, 1'b1);
      chk("s5_empty_a", 32'(out_valid), 32'h0);
      apply(1'b0, 8'h00, 1'b0, 1'b0);
      chk("s5_empty_b", 32'(out_valid), 32'h0);
      chk("s5_empty_count", 32'(out_count), 32'd0);
    end

    // Scenario 6: single-lane instance under continuous traffic
    do_reset();
    prev = '0;
    for (int k = 0; k < 11; k++) begin
      @(posedge clock);
      #2;
      v1 = (k < 10); d1 = 8'(k * 7 + 3); or1 = 1'b1;
      #1;
      if (k >= 1) begin
        chk($sformatf("s6_valid%0d", k), 32'(ov1), 32'h1);
        chk($sformatf("s6_out%0d", k), 32'(out1), 32'(prev));
        chk($sformatf("s6_count%0d", k), 32'(cnt1), 32'h1);
        chk($sformatf("s6_in_ready%0d", k), 32'(ir1), 32'h1);
      end
      prev = d1;
    end
    @(posedge clock);
    #2;
    v1 = 1'b0; or1 = 1'b0;
    #1;
    chk("s6_drained", 32'(ov1), 32'h0);

    // Randomised traffic against the queue model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      logic iv, ordy, fl;
      logic [7:0] d;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = FLUSH_EN && ($urandom_range(0, 9) == 0);
      d    = 8'($urandom);
      apply(iv, d, ordy, fl);
      chk("rnd_in_ready", 32'(in_ready), 32'(!m_full || ordy));
      chk("rnd_out_valid", 32'(out_valid), 32'(m_full));
      chk("rnd_out", out, model_out());
      chk("rnd_count", 32'(out_count), 32'(m_q.size()));
      if (!FLUSH_EN && out_valid) chk("rnd_full_count", 32'(out_count), 32'(WC));
      model_step(iv, d, ordy, fl);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
